inst_fetch: RTL and testbench

//  Fetch stage sitting directly downstream of the PC register. Latches the current PC,

---
 rtl/inst_fetch.sv | 146 ++++++++++++++
 tb/tb_inst_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Fetch stage: latches the PC, runs one instruction read at a time on an SRAM-like bus,
// and presents the word and its PC on a registered F/D output backed by a one-entry skid buffer.
module inst_fetch #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  output logic          pc_en,
  input  logic          flush,
  input  logic          stall_d,
  output logic          inst_req,
  output logic [AW-1:0] inst_addr,
  input  logic          inst_addr_ok,
  input  logic          inst_data_ok,
  input  logic [DW-1:0] inst_rdata,
  output logic          inst_valid,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_adel
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;

  state_t        state, state_nx;
  logic          discard, discard_nx;
  logic [AW-1:0] addr_r, addr_nx;
  logic          hold_valid, hold_valid_nx;
  logic [DW-1:0] hold_data, hold_data_nx;
  logic [AW-1:0] hold_pc, hold_pc_nx;
  logic          valid_nx, adel_nx;
  logic [DW-1:0] inst_nx;
  logic [AW-1:0] inst_pc_nx;
  logic          out_free;

  assign inst_addr = addr_r;
  assign out_free  = !inst_valid || !stall_d;

  always_comb begin
    state_nx      = state;
    discard_nx    = discard;
    addr_nx       = addr_r;
    hold_valid_nx = hold_valid;
    hold_data_nx  = hold_data;
    hold_pc_nx    = hold_pc;
    valid_nx      = inst_valid && stall_d;
    inst_nx       = inst;
    inst_pc_nx    = inst_pc;
    adel_nx       = inst_adel;
    inst_req      = 1'b0;
    pc_en         = 1'b0;

    unique case (state)
      IDLE: begin
        if (!flush && out_free) begin
          addr_nx = pc;
          if (pc[1:0] == 2'b00) begin
            state_nx = REQ;
          end else begin
            valid_nx   = 1'b1;
            inst_nx    = '0;
            inst_pc_nx = pc;
            adel_nx    = 1'b1;
            state_nx   = ERR;
          end
        end
      end
      REQ: begin
        inst_req = 1'b1;
        pc_en    = inst_addr_ok && !discard && !flush;
        if (inst_addr_ok) state_nx = WAIT;
      end
      WAIT: begin
        if (inst_data_ok) begin
          if (discard || flush) begin
            discard_nx = 1'b0;
            state_nx   = IDLE;
          end else if (out_free) begin
            valid_nx   = 1'b1;
            inst_nx    = inst_rdata;
            inst_pc_nx = addr_r;
            adel_nx    = 1'b0;
            state_nx   = IDLE;
          end else begin
            hold_valid_nx = 1'b1;
            hold_data_nx  = inst_rdata;
            hold_pc_nx    = addr_r;
            state_nx      = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_d && hold_valid) begin
          valid_nx      = 1'b1;
          inst_nx       = hold_data;
          inst_pc_nx    = hold_pc;
          adel_nx       = 1'b0;
          hold_valid_nx = 1'b0;
          state_nx      = IDLE;
        end
      end
      ERR: begin
      end
      default: state_nx = IDLE;
    endcase

    // A bus transaction already in flight must still finish; only its data is dropped.
    if (flush) begin
      valid_nx      = 1'b0;
      hold_valid_nx = 1'b0;
      unique case (state)
        REQ:     discard_nx = 1'b1;
        WAIT:    discard_nx = !inst_data_ok;
        default: state_nx   = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      discard    <= 1'b0;
      addr_r     <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_pc    <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_adel  <= 1'b0;
    end else begin
      state      <= state_nx;
      discard    <= discard_nx;
      addr_r     <= addr_nx;
      hold_valid <= hold_valid_nx;
      hold_data  <= hold_data_nx;
      hold_pc    <= hold_pc_nx;
      inst_valid <= valid_nx;
      inst       <= inst_nx;
      inst_pc    <= inst_pc_nx;
      inst_adel  <= adel_nx;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: PC register and memory responder models, directed corner sequences,
// an address table and a randomized in-order delivery scoreboard.
module tb_inst_fetch;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] RESET_PC = 32'hbfc0_0000;

  logic          clk = 1'b0;
  logic          rst, flush, stall_d;
  logic [AW-1:0] pc;
  logic          pc_en, inst_req, inst_addr_ok, inst_data_ok, inst_valid, inst_adel;
  logic [AW-1:0] inst_addr, inst_pc;
  logic [DW-1:0] inst_rdata, inst;

  inst_fetch #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .flush(flush), .stall_d(stall_d),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_adel(inst_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'h9bc8_0001;
  endfunction

  // PC register: redirect load wins over the fetch-driven advance
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_load_val = '0;
  always @(posedge clk or negedge rst)
    if (!rst)         pc <= RESET_PC;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_en)   pc <= pc + 32'd4;

  int            pc_en_cnt = 0, acc_cnt = 0, unstable = 0;
  logic          req_wait = 1'b0;
  logic [AW-1:0] req_wait_addr = '0, last_acc = '0;
  logic [95:0]   got_q[$];
  always @(posedge clk) begin
    if (pc_en) pc_en_cnt <= pc_en_cnt + 1;
    if (inst_req && inst_addr_ok) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= inst_addr;
    end
    req_wait      <= inst_req && !inst_addr_ok;
    req_wait_addr <= inst_addr;
    if (req_wait && inst_req && inst_addr != req_wait_addr) unstable <= unstable + 1;
    if (rst && !flush && inst_valid && !stall_d) got_q.push_back({31'd0, inst_adel, inst_pc, inst});
  end

  int addr_delay = 0, data_delay = 0;
  bit mem_rand = 1'b0;
  initial begin : responder
    int acnt, dcnt, ad, dd;
    bit pend;
    logic [AW-1:0] paddr;
    acnt = 0; dcnt = 0; ad = 0; dd = 0; pend = 1'b0; paddr = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    forever begin
      @(negedge clk);
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      if (pend) begin
        if (dcnt >= dd) begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_word(paddr);
          pend         = 1'b0;
        end else dcnt++;
      end else if (inst_req) begin
        if (acnt == 0) ad = mem_rand ? int'($urandom_range(3, 0)) : addr_delay;
        if (acnt >= ad) begin
          inst_addr_ok = 1'b1;
          paddr = inst_addr;
          pend  = 1'b1;
          dcnt  = 0;
          acnt  = 0;
          dd    = mem_rand ? int'($urandom_range(3, 0)) : data_delay;
        end else acnt++;
      end
    end
  end

  int unsigned passed = 0, total = 0;
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!inst_valid && n < max);
    check(name, 96'(inst_valid), 96'(1));
  endtask

  task automatic restart(input logic [AW-1:0] a);
    @(negedge clk);
    flush = 1'b1; pc_load = 1'b1; pc_load_val = a;
    @(negedge clk);
    flush = 1'b0; pc_load = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   96'(inst_req),   96'(0));
    check({tag, "_addr"},  96'(inst_addr),  96'(0));
    check({tag, "_valid"}, 96'(inst_valid), 96'(0));
    check({tag, "_inst"},  96'(inst),       96'(0));
    check({tag, "_pc"},    96'(inst_pc),    96'(0));
    check({tag, "_adel"},  96'(inst_adel),  96'(0));
    check({tag, "_pc_en"}, 96'(pc_en),      96'(0));
  endtask

  typedef struct {
    logic [AW-1:0] pc;
    logic          exp_adel;
    logic [DW-1:0] exp_inst;
    int            exp_acc;
  } vec_t;

  initial begin : main
    vec_t          vecs[8];
    logic [AW-1:0] tpcs[8];
    logic [AW-1:0] exp_pc;
    int            pe0, acc0, gb, n, unst0;
    logic          req_seen;

    tpcs = '{32'hbfc0_0010, 32'hbfc0_0011, 32'hbfc0_0012, 32'hbfc0_0013,
             32'h0000_0000, 32'h8000_1234, 32'hffff_fffc, 32'h0000_0007};
    foreach (tpcs[i]) begin
      vecs[i].pc       = tpcs[i];
      vecs[i].exp_adel = (tpcs[i][1:0] != 2'b00);
      vecs[i].exp_inst = vecs[i].exp_adel ? '0 : mem_word(tpcs[i]);
      vecs[i].exp_acc  = vecs[i].exp_adel ? 0 : 1;
    end

    rst = 1'b0; flush = 1'b0; stall_d = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");

    // 1: first fetch after reset, zero-wait memory
    @(negedge clk) rst = 1'b1;
    cyc();
    check("t1_req",  96'(inst_req),  96'(1));
    check("t1_addr", 96'(inst_addr), 96'(RESET_PC));
    cyc();
    check("t1_pc_en_pulse", 96'(pc_en_cnt), 96'(1));
    cyc();
    check("t1_valid", 96'(inst_valid), 96'(1));
    check("t1_inst",  96'(inst),       96'(32'h2408_0001));
    check("t1_pc",    96'(inst_pc),    96'(RESET_PC));
    check("t1_adel",  96'(inst_adel),  96'(0));

    // 2: stalled full output blocks new issues; words stay in order
    req_seen = 1'b0;
    repeat (6) begin
      cyc();
      if (inst_req) req_seen = 1'b1;
    end
    check("t2_no_req",  96'(req_seen), 96'(0));
    check("t2_held_pc", 96'(inst_pc),  96'(RESET_PC));
    @(negedge clk) stall_d = 1'b0;
    wait_valid("t2_word2_valid", 12);
    @(negedge clk) stall_d = 1'b1;
    check("t2_word2_pc",   96'(inst_pc), 96'(RESET_PC + 32'd4));
    check("t2_word2_inst", 96'(inst),    96'(mem_word(RESET_PC + 32'd4)));
    check("t2_consumed_n", 96'(got_q.size()), 96'(1));
    check("t2_consumed_0", got_q[0], {31'd0, 1'b0, RESET_PC, mem_word(RESET_PC)});

    // 3: addr_ok delayed three cycles
    addr_delay = 3;
    restart(32'hbfc0_0100);
    pe0 = pc_en_cnt;
    n = 0;
    while (!inst_req && n < 5) begin cyc(); n++; end
    check("t3_req", 96'(inst_req), 96'(1));
    n = 0;
    while (inst_req && n < 10) begin
      check("t3_addr_stable", 96'(inst_addr), 96'(32'hbfc0_0100));
      n++;
      cyc();
    end
    check("t3_req_cycles", 96'(n), 96'(4));
    addr_delay = 0;
    wait_valid("t3_valid", 12);
    check("t3_pc",    96'(inst_pc),         96'(32'hbfc0_0100));
    check("t3_pc_en", 96'(pc_en_cnt - pe0), 96'(1));

    // 4: flush while waiting for data, redirect to bfc00380
    data_delay = 3;
    restart(32'hbfc0_0200);
    pe0 = pc_en_cnt;
    acc0 = acc_cnt;
    n = 0;
    while (pc_en_cnt == pe0 && n < 10) begin cyc(); n++; end
    @(negedge clk);
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'hbfc0_0380;
    @(negedge clk);
    flush = 1'b0; pc_load = 1'b0;
    pe0 = pc_en_cnt;
    wait_valid("t4_valid", 25);
    data_delay = 0;
    check("t4_pc",       96'(inst_pc),         96'(32'hbfc0_0380));
    check("t4_inst",     96'(inst),            96'(mem_word(32'hbfc0_0380)));
    check("t4_req_addr", 96'(last_acc),        96'(32'hbfc0_0380));
    check("t4_acc",      96'(acc_cnt - acc0),  96'(2));
    check("t4_pc_en",    96'(pc_en_cnt - pe0), 96'(1));

    // 5: misaligned PC: no bus access, error word held until flush
    acc0 = acc_cnt;
    restart(32'hbfc0_0002);
    cyc(); cyc();
    check("t5_valid", 96'(inst_valid), 96'(1));
    check("t5_adel",  96'(inst_adel),  96'(1));
    check("t5_inst",  96'(inst),       96'(0));
    check("t5_pc",    96'(inst_pc),    96'(32'hbfc0_0002));
    req_seen = 1'b0;
    repeat (4) begin
      cyc();
      if (inst_req) req_seen = 1'b1;
    end
    check("t5_no_req",     96'(req_seen),       96'(0));
    check("t5_still_held", 96'(inst_valid),     96'(1));
    check("t5_no_acc",     96'(acc_cnt - acc0), 96'(0));
    @(negedge clk) flush = 1'b1;
    cyc();
    check("t5_flush_clears", 96'(inst_valid), 96'(0));
    @(negedge clk) flush = 1'b0;

    // 6: reset during WAIT, late data_ok after release
    data_delay = 5;
    restart(32'hbfc0_0400);
    pe0 = pc_en_cnt;
    n = 0;
    while (pc_en_cnt == pe0 && n < 10) begin cyc(); n++; end
    @(negedge clk) rst = 1'b0;
    #1 check_zero("t6_reset");
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    wait_valid("t6_valid", 30);
    data_delay = 0;
    check("t6_pc",   96'(inst_pc), 96'(RESET_PC));
    check("t6_inst", 96'(inst),    96'(mem_word(RESET_PC)));

    // address table: alignment decides bus access vs. address-error word
    foreach (vecs[i]) begin
      acc0 = acc_cnt;
      restart(vecs[i].pc);
      wait_valid("tab_valid", 12);
      check("tab_pc",   96'(inst_pc),        96'(vecs[i].pc));
      check("tab_adel", 96'(inst_adel),      96'(vecs[i].exp_adel));
      check("tab_inst", 96'(inst),           96'(vecs[i].exp_inst));
      check("tab_acc",  96'(acc_cnt - acc0), 96'(vecs[i].exp_acc));
    end

    // random memory latency and decode stalls: sequential PCs delivered once, in order
    mem_rand = 1'b1;
    restart(32'hbfc0_1000);
    gb    = got_q.size();
    acc0  = acc_cnt;
    pe0   = pc_en_cnt;
    unst0 = unstable;
    repeat (600) begin
      @(negedge clk);
      stall_d = ($urandom_range(3, 0) == 0);
    end
    @(negedge clk) stall_d = 1'b1;
    repeat (25) cyc();
    n = got_q.size() - gb;
    check("rand_progress", 96'(n >= 20), 96'(1));
    for (int k = 0; k < n; k++) begin
      exp_pc = 32'hbfc0_1000 + 32'(4 * k);
      check("rand_word", got_q[gb + k], {31'd0, 1'b0, exp_pc, mem_word(exp_pc)});
    end
    check("rand_accounted", 96'(acc_cnt - acc0),   96'(n + int'(inst_valid)));
    check("rand_pc_en",     96'(pc_en_cnt - pe0),  96'(acc_cnt - acc0));
    check("rand_addr_hold", 96'(unstable - unst0), 96'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
